// File: rtl/hex7seg_pkg.sv
// ============================================================================
// Module  : hex7seg_pkg
// Brief   : Segment-pattern type and hex glyph constants, {a..g}, a = MSB,
//           expressed in lit-high sense.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package hex7seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0   = 7'b1111110;
    localparam seg_t SEG_1   = 7'b0110000;
    localparam seg_t SEG_2   = 7'b1101101;
    localparam seg_t SEG_3   = 7'b1111001;
    localparam seg_t SEG_4   = 7'b0110011;
    localparam seg_t SEG_5   = 7'b1011011;
    localparam seg_t SEG_6   = 7'b1011111;
    localparam seg_t SEG_7   = 7'b1110000;
    localparam seg_t SEG_8   = 7'b1111111;
    localparam seg_t SEG_9   = 7'b1111011;
    localparam seg_t SEG_A   = 7'b1110111;
    // b and d are lowercase glyphs so they differ from 8 and 0
    localparam seg_t SEG_B   = 7'b0011111;
    localparam seg_t SEG_C   = 7'b1001110;
    localparam seg_t SEG_D   = 7'b0111101;
    localparam seg_t SEG_E   = 7'b1001111;
    localparam seg_t SEG_F   = 7'b1000111;
    localparam seg_t SEG_OFF = 7'b0000000;

endpackage

`default_nettype wire

// File: rtl/hex7seg_lut.sv
// ============================================================================
// Module  : hex7seg_lut
// Brief   : Combinational nibble -> {a..g} and dot, lit-high sense.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module hex7seg_lut
    import hex7seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg,
    output logic       o_dot
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

    // Dot flags a non-decimal digit (10..15)
    assign o_dot = (i_nibble > 4'd9);

endmodule

`default_nettype wire

// File: rtl/hex7seg_decoder.sv
// ============================================================================
// Module  : hex7seg_decoder
// Brief   : Registered hex-to-seven-segment decoder with decimal-point flag
//           and selectable output polarity.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module hex7seg_decoder
    import hex7seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       dot
);

    // Off level per polarity; XOR with it also performs the inversion
    localparam logic [7:0] C_OFF = {8{ACTIVE_LOW}};

    seg_t       w_seg;
    logic       w_dot;
    logic [7:0] w_drive;
    logic [7:0] r_out;

    hex7seg_lut u_lut (
        .i_nibble (in),
        .o_seg    (w_seg),
        .o_dot    (w_dot)
    );

    assign w_drive = {w_seg, w_dot} ^ C_OFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= C_OFF;
        end else begin
            r_out <= w_drive;
        end
    end

    assign {a, b, c, d, e, f, g, dot} = r_out;

endmodule

`default_nettype wire

// File: tb/tb_hex7seg_decoder.sv
// ============================================================================
// Module  : tb_hex7seg_decoder
// Brief   : Scoreboard bench for both output polarities of hex7seg_decoder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_hex7seg_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] in;
    logic       ha, hb, hc, hd, he, hf, hg, hdot;
    logic       la, lb, lc, ld, le, lf, lg, ldot;
    logic [7:0] w_hi;
    logic [7:0] w_lo;

    int n_checks;
    int n_err;

    logic [7:0] exp_q[$];

    hex7seg_decoder #(.ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk (clk), .rst (rst), .in (in),
        .a (ha), .b (hb), .c (hc), .d (hd), .e (he), .f (hf), .g (hg),
        .dot (hdot)
    );

    hex7seg_decoder #(.ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk (clk), .rst (rst), .in (in),
        .a (la), .b (lb), .c (lc), .d (ld), .e (le), .f (lf), .g (lg),
        .dot (ldot)
    );

    assign w_hi = {ha, hb, hc, hd, he, hf, hg, hdot};
    assign w_lo = {la, lb, lc, ld, le, lf, lg, ldot};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: glyph table {a..g} in lit-high sense, dot for digits above 9
    function automatic logic [7:0] model(input int v);
        logic [6:0] glyph [16];
        glyph = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                  7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                  7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        return {glyph[v], (v >= 10) ? 1'b1 : 1'b0};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic apply(input int v);
        @(negedge clk);
        in = v[3:0];
        exp_q.push_back(model(v));
    endtask

    // Monitor: outputs are valid one edge after each issued nibble
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("decode_hi", w_hi, e);
                chk("decode_lo", w_lo, ~e);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b0;
        in       = 4'd8;

        // Asynchronous reset before the first clock edge
        #2 rst = 1'b1;
        #1;
        chk("reset_async_hi", w_hi, 8'h00);
        chk("reset_async_lo", w_lo, 8'hFF);
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold_hi", w_hi, 8'h00);
            chk("reset_hold_lo", w_lo, 8'hFF);
        end

        // Full sweep; release reset on the same falling edge as the first value
        @(negedge clk);
        rst = 1'b0;
        in  = 4'd0;
        exp_q.push_back(model(0));
        for (int v = 1; v < 16; v++) apply(v);

        // Latency and hold: 3 then 4, checked before the next rising edge
        apply(3);
        apply(4);
        #1;
        chk("hold_3_hi", w_hi, model(3));
        chk("hold_3_lo", w_lo, ~model(3));

        // Polarity spot checks
        apply(1);
        apply(12);
        apply(9);
        apply(10);

        // Random stream with a sub-cycle reset pulse in the middle
        for (int k = 0; k < 40; k++) begin
            apply(int'($urandom_range(0, 15)));
            if (k == 20) begin
                #1 rst = 1'b1;
                #1;
                chk("midreset_hi", w_hi, 8'h00);
                chk("midreset_lo", w_lo, 8'hFF);
                #1 rst = 1'b0;
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hex7seg_decoder.md
# hex7seg_decoder

Registered hexadecimal-to-seven-segment decoder for a single display digit. It converts a 4-bit nibble into segment drives a–g plus a decimal-point drive, updating once per clock. It sits between the digit-select/multiplex logic and the display pins. One instance is used per digit, or one instance is shared behind a digit multiplexer.

## Interface

Parameters:
- ACTIVE_LOW, default 0: 0 means segment/dot lit = 1 (common cathode); 1 means all outputs are inverted (common anode).

Ports:
- clk, input, 1: sole clock; all outputs registered on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in, input, 4: hex digit value 0–15.
- a, b, c, d, e, f, g, output, 1 each: segment drives; packed view {a,b,c,d,e,f,g} with a as MSB.
- dot, output, 1: decimal-point drive.

## Operation

- Segment naming is the standard convention: a = top, b = top-right, c = bottom-right, d = bottom, e = bottom-left, f = top-left, g = middle.
- Lit patterns {a..g} at ACTIVE_LOW=0:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
- Letters b and d are lowercase so they are distinguishable from 8 and 0.
- dot is lit for in = 10..15 and off for in = 0..9. It flags a non-decimal digit.
- ACTIVE_LOW=1 inverts all eight outputs, including the reset value.
- The mapping is total: every 4-bit value has a defined pattern. There is no X and no default-blank case.
- There is no internal state beyond the output register.

## Timing

- Latency is exactly one clock. The outputs after rising edge N reflect the `in` value sampled at edge N.
- `in` is sampled every cycle. There is no enable and no handshake.
- Reset assertion asynchronously forces all outputs to the "off" level:
  - all 0 when ACTIVE_LOW=0,
  - all 1 when ACTIVE_LOW=1.
- Outputs stay off while rst is high, regardless of `in`.
- On reset deassertion, the first rising edge loads the decode of the current `in`.
- If reset asserts mid-stream, the outputs go off immediately, with no wait for a clock edge, and the pending value is discarded.
- The outputs are glitch-free: they come directly from flip-flops with no combinational path from `in`.

## Structure

- Shared package hex7seg_pkg:
  - a 7-bit segment-pattern type,
  - the 16 named pattern constants above,
  - a constant SEG_OFF = 7'b0.
- One natural sub-module, hex7seg_lut: purely combinational, 4-bit in → {a..g, dot}, in active-high sense.
- Top level:
  - instantiates hex7seg_lut,
  - applies the ACTIVE_LOW inversion,
  - registers the 8 outputs with asynchronous reset to the off level.

## Test plan

- Reset: assert rst with in = 8. Outputs go to 0000000 and dot = 0 immediately, without a clock edge, and hold while rst is high.
- Full sweep: release reset, then apply in = 0..15 on consecutive cycles. Each pattern matches the list one cycle later, e.g. in = 0 → 1111110, in = 10 → 1110111 with dot = 1, in = 15 → 1000111 with dot = 1.
- Dot boundary: in = 9 → 1111011 with dot = 0; next cycle in = 10 → dot = 1.
- Latency and hold: change in from 3 to 4 between edges. Outputs stay 1111001 until the next rising edge, then become 0110011.
- Mid-stream reset: while sweeping, pulse rst for less than one clock period. Outputs blank at once, then resume decoding the current `in` on the first edge after release.
- ACTIVE_LOW=1 instance: under reset, all outputs = 1. in = 1 → {a..g} = 1001111 with dot = 1; in = 12 → 0110001 with dot = 0.
